// File: rtl/projectile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : projectile_ctrl_pkg
// Brief    : Shared constants and state encoding for the projectile controller.
// Revision : 1.0
// ============================================================================
package projectile_ctrl_pkg;

   localparam logic [9:0] PARK = 10'h3FF;
   localparam int H_RES = 640;
   localparam int V_RES = 480;

   localparam int DEF_SPEED      = 4;
   localparam int DEF_MUZZLE_OFF = 16;
   localparam int DEF_TOP_LIMIT  = 35;
   localparam int DEF_COOLDOWN   = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_FLY  = 3'b010,
      S_COOL = 3'b100
   } state_t;

endpackage
`default_nettype wire

// File: rtl/projectile_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : projectile_ctrl_if
// Brief    : Player/control inputs and projectile outputs of the controller.
// Revision : 1.0
// ============================================================================
interface projectile_ctrl_if;
   logic       fire;
   logic       move_tick;
   logic [9:0] player_h;
   logic [9:0] player_v;
   logic       hit;
   logic [9:0] projectile_h;
   logic [9:0] projectile_v;
   logic       active;
   logic       ready;
   logic [7:0] shots;

   modport master (
      output fire, move_tick, player_h, player_v, hit,
      input  projectile_h, projectile_v, active, ready, shots
   );

   modport slave (
      input  fire, move_tick, player_h, player_v, hit,
      output projectile_h, projectile_v, active, ready, shots
   );
endinterface
`default_nettype wire

// File: rtl/projectile_ctrl_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Brief    : Rising-edge detector; history resets high so a held input is
//            not seen as a fresh edge after reset.
// Revision : 1.0
// ============================================================================
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic rise
);
   logic r_in_q;

   always_ff @(posedge clk) begin
      if (reset) r_in_q <= 1'b1;
      else       r_in_q <= in;
   end

   assign rise = in & ~r_in_q;
endmodule
`default_nettype wire

// File: rtl/projectile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : projectile_ctrl
// Brief    : Single-shot projectile launcher: launch, upward flight, cooldown.
// Revision : 1.0
// ============================================================================
module projectile_ctrl
   import projectile_ctrl_pkg::*;
#(
   parameter int SPEED      = DEF_SPEED,
   parameter int MUZZLE_OFF = DEF_MUZZLE_OFF,
   parameter int TOP_LIMIT  = DEF_TOP_LIMIT,
   parameter int COOLDOWN   = DEF_COOLDOWN
) (
   input  logic               clk,
   input  logic               reset,
   projectile_ctrl_if.slave   bus
);
   // 11-bit thresholds so the comparisons cannot wrap
   localparam logic [10:0] c_LAUNCH_MIN = 11'(TOP_LIMIT + MUZZLE_OFF);
   localparam logic [10:0] c_FLY_MIN    = 11'(TOP_LIMIT + SPEED);

   state_t     r_state;
   logic [9:0] r_proj_h;
   logic [9:0] r_proj_v;
   logic       r_active;
   logic       r_ready;
   logic [7:0] r_shots;
   logic [7:0] r_count;
   logic       w_fire_rise;

   rise_detect u_fire_rise (
      .clk   (clk),
      .reset (reset),
      .in    (bus.fire),
      .rise  (w_fire_rise)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_proj_h <= PARK;
         r_proj_v <= PARK;
         r_active <= 1'b0;
         r_ready  <= 1'b1;
         r_shots  <= 8'd0;
         r_count  <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fire_rise && ({1'b0, bus.player_v} >= c_LAUNCH_MIN)) begin
                  r_state  <= S_FLY;
                  r_proj_h <= bus.player_h;
                  r_proj_v <= bus.player_v - 10'(MUZZLE_OFF);
                  r_shots  <= r_shots + 8'd1;
                  r_active <= 1'b1;
                  r_ready  <= 1'b0;
               end
            end
            S_FLY: begin
               // A hit wins over motion; a step past the top also ends flight
               if (bus.hit || (bus.move_tick && ({1'b0, r_proj_v} < c_FLY_MIN))) begin
                  r_state  <= S_COOL;
                  r_proj_h <= PARK;
                  r_proj_v <= PARK;
                  r_count  <= 8'(COOLDOWN);
                  r_active <= 1'b0;
               end else if (bus.move_tick) begin
                  r_proj_v <= r_proj_v - 10'(SPEED);
               end
            end
            S_COOL: begin
               if (bus.move_tick) begin
                  if (r_count <= 8'd1) begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                     r_count <= 8'd0;
                  end else begin
                     r_count <= r_count - 8'd1;
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_proj_h <= PARK;
               r_proj_v <= PARK;
               r_active <= 1'b0;
               r_ready  <= 1'b1;
               r_count  <= 8'd0;
            end
         endcase
      end
   end

   assign bus.projectile_h = r_proj_h;
   assign bus.projectile_v = r_proj_v;
   assign bus.active       = r_active;
   assign bus.ready        = r_ready;
   assign bus.shots        = r_shots;
endmodule
`default_nettype wire

// File: tb/tb_projectile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_projectile_ctrl
// Brief    : Directed and random checks of projectile_ctrl against a model.
// Revision : 1.0
// ============================================================================
module tb_projectile_ctrl;
   localparam int P_READY = 0;
   localparam int P_FLY   = 1;
   localparam int P_COOL  = 2;
   localparam int PK      = 1023;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   // reference model
   int m_phase, m_h, m_v, m_shots, m_cool_left;
   bit m_fire_prev;

   projectile_ctrl_if bus ();

   projectile_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp))
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit rs, input bit f, input bit t,
                               input bit h, input int ph, input int pv);
      bit rise;
      if (rs) begin
         m_phase = P_READY; m_h = PK; m_v = PK; m_shots = 0;
         m_fire_prev = 1'b1; m_cool_left = 0;
         return;
      end
      rise = f && !m_fire_prev;
      m_fire_prev = f;
      if (m_phase == P_READY) begin
         if (rise && pv >= 35 + 16) begin
            m_phase = P_FLY; m_h = ph; m_v = pv - 16;
            m_shots = (m_shots + 1) % 256;
         end
      end else if (m_phase == P_FLY) begin
         if (h || (t && m_v - 4 < 35)) begin
            m_phase = P_COOL; m_h = PK; m_v = PK; m_cool_left = 8;
         end else if (t) begin
            m_v = m_v - 4;
         end
      end else if (t) begin
         m_cool_left--;
         if (m_cool_left == 0) m_phase = P_READY;
      end
   endtask

   task automatic step(input bit rs, input bit f, input bit t, input bit h,
                       input int ph, input int pv);
      reset         = rs;
      bus.fire      = f;
      bus.move_tick = t;
      bus.hit       = h;
      bus.player_h  = 10'(ph);
      bus.player_v  = 10'(pv);
      @(posedge clk);
      model_update(rs, f, t, h, ph, pv);
      #1;
      chk("active", 32'(bus.active), int'(m_phase == P_FLY));
      chk("ready",  32'(bus.ready),  int'(m_phase == P_READY));
      chk("proj_h", 32'(bus.projectile_h), m_h);
      chk("proj_v", 32'(bus.projectile_v), m_v);
      chk("shots",  32'(bus.shots), m_shots);
   endtask

   initial begin
      bit f;
      int pv;
      m_phase = P_READY; m_h = PK; m_v = PK; m_shots = 0;
      m_fire_prev = 1'b1; m_cool_left = 0;

      // reset state
      step(1, 0, 0, 0, 320, 400);
      step(1, 1, 1, 1, 320, 400);
      chk("rst_ready", 32'(bus.ready), 1);
      chk("rst_park", 32'(bus.projectile_v), PK);

      // launch from (320,400)
      step(0, 0, 0, 0, 320, 400);
      step(0, 1, 0, 0, 320, 400);
      chk("launch_active", 32'(bus.active), 1);
      chk("launch_h", 32'(bus.projectile_h), 320);
      chk("launch_v", 32'(bus.projectile_v), 384);
      chk("launch_shots", 32'(bus.shots), 1);

      // five moves, fire held; hit in IDLE-free flight ignored only by state
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 0, 100, 300);
         step(0, 1, 0, 0, 100, 300);
      end
      chk("fly_v", 32'(bus.projectile_v), 364);
      chk("fly_h", 32'(bus.projectile_h), 320);

      // hit and move_tick together: cooldown, no decrement
      step(0, 1, 1, 1, 320, 400);
      chk("hit_park", 32'(bus.projectile_v), PK);
      chk("hit_active", 32'(bus.active), 0);

      // cooldown with hit ignored, fire held into IDLE
      for (int i = 0; i < 8; i++) begin
         chk("cool_not_ready", 32'(bus.ready), 0);
         step(0, 1, 1, 1, 320, 400);
         step(0, 1, 0, 0, 320, 400);
      end
      chk("cool_ready", 32'(bus.ready), 1);
      step(0, 1, 0, 1, 320, 400);
      chk("held_no_launch", 32'(bus.shots), 1);

      // low player refused, boundary 50 refused, 51 accepted -> proj_v 35? no: use 54 -> 38
      step(0, 0, 0, 0, 320, 40);
      step(0, 1, 0, 0, 320, 40);
      chk("low_refused", 32'(bus.shots), 1);
      step(0, 0, 0, 0, 320, 50);
      step(0, 1, 0, 0, 320, 50);
      chk("edge_refused", 32'(bus.ready), 1);
      step(0, 0, 0, 0, 200, 54);
      step(0, 1, 0, 0, 200, 54);
      chk("top_launch_v", 32'(bus.projectile_v), 38);
      step(0, 0, 1, 0, 200, 54);
      chk("top_exit_h", 32'(bus.projectile_h), PK);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 200, 54);
      chk("top_cool_7", 32'(bus.ready), 0);
      step(0, 0, 1, 0, 200, 54);
      chk("top_cool_8", 32'(bus.ready), 1);

      // reset mid-flight with fire held
      step(0, 0, 0, 0, 320, 400);
      step(0, 1, 0, 0, 320, 400);
      step(0, 1, 1, 0, 320, 400);
      step(1, 1, 0, 0, 320, 400);
      chk("midrst_shots", 32'(bus.shots), 0);
      chk("midrst_park", 32'(bus.projectile_h), PK);
      step(0, 1, 0, 0, 320, 400);
      step(0, 1, 0, 0, 320, 400);
      chk("midrst_no_launch", 32'(bus.active), 0);

      // randomized traffic
      f = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 3) f = ~f;
         case ($urandom_range(0, 7))
            0:       pv = 50;
            1:       pv = 51;
            default: pv = int'($urandom_range(0, 479));
         endcase
         step(($urandom_range(0, 99) == 0), f, ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 9) == 0), int'($urandom_range(0, 639)), pv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/projectile_ctrl.md
PROJECTILE_CTRL -- requirements
Module: projectile_ctrl

Interface
REQ-001 The block SHALL take parameter SPEED, default 4: pixels moved upward per move_tick.
REQ-002 The block SHALL take parameter MUZZLE_OFF, default 16: vertical offset of launch point above player_v.
REQ-003 The block SHALL take parameter TOP_LIMIT, default 35: smallest legal projectile_v (top of visible area).
REQ-004 The block SHALL take parameter COOLDOWN, default 8: move_ticks spent in cooldown before re-arming.
REQ-005 clk  input  1  sole system clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 fire  input  1  fire button, level, already debounced; only a rising edge launches.
REQ-008 move_tick  input  1  one-clk pulse per frame; paces motion and cooldown.
REQ-009 player_h  input  10  player centre column.
REQ-010 player_v  input  10  player centre row.
REQ-011 hit  input  1  hit indication from the enemy hit detector.
REQ-012 projectile_h  output  10  projectile column; PARK (10'h3FF) when not flying.
REQ-013 projectile_v  output  10  projectile row; PARK (10'h3FF) when not flying.
REQ-014 active  output  1  high exactly while state is FLY.
REQ-015 ready  output  1  high exactly while state is IDLE (a new shot is accepted).
REQ-016 shots  output  8  count of accepted launches, wraps 255->0.

Function
REQ-017 States SHALL be IDLE, FLY, COOL; state register one-hot, 3 bits.
REQ-018 fire_rise SHALL be fire & ~fire_q, fire_q registered each clk; a held fire launches at most once.
REQ-019 In IDLE, fire_rise with player_v >= TOP_LIMIT+MUZZLE_OFF SHALL, on the next edge, load projectile_h=player_h, projectile_v=player_v-MUZZLE_OFF, increment shots, enter FLY.
REQ-020 In IDLE, fire_rise with player_v < TOP_LIMIT+MUZZLE_OFF SHALL be refused: state, position, shots unchanged.
REQ-021 fire_rise outside IDLE SHALL be ignored and not queued.
REQ-022 In FLY, hit=1 SHALL enter COOL next edge, regardless of move_tick (hit has priority).
REQ-023 In FLY, move_tick with hit=0 and projectile_v < TOP_LIMIT+SPEED SHALL enter COOL (no underflow/wrap).
REQ-024 In FLY, move_tick with hit=0 otherwise SHALL set projectile_v -= SPEED; projectile_h constant during flight.
REQ-025 Entry to COOL SHALL set projectile_h/v to PARK and load cooldown counter with COOLDOWN.
REQ-026 In COOL, each move_tick SHALL decrement the counter; move_tick at count 1 SHALL enter IDLE; COOLDOWN=0 SHALL exit on first move_tick.
REQ-027 hit in IDLE or COOL SHALL be ignored.
REQ-028 Outputs SHALL be registered; launch-to-active latency one clk after the fire_rise edge.

Reset
REQ-029 reset=1 at a clk edge SHALL force IDLE, projectile_h/v=PARK, active=0, ready=1, shots=0, fire_q=1, counter=0, overriding all other inputs.
REQ-030 reset mid-flight or mid-cooldown SHALL abort immediately; fire held through reset SHALL NOT launch (fire_q=1).

Structure
REQ-031 Shared package SHALL hold PARK, screen constants, state encodings, default SPEED/TOP_LIMIT.
REQ-032 Rising-edge detection SHALL be one sub-module, rise_detect (clk, reset, in, rise).

Verification
REQ-033 player=(320,400), fire 0->1 -> next clk active=1, proj=(320,384), shots=1.
REQ-034 From (320,384), 5 move_ticks, hit=0 -> proj_v=364, proj_h=320, active=1.
REQ-035 proj_v=38, move_tick -> COOL, proj=(3FF,3FF); 8 move_ticks later ready=1.
REQ-036 FLY, hit=1 and move_tick same clk -> COOL, proj_v not decremented, PARK next clk.
REQ-037 fire held high through FLY/COOL into IDLE -> no launch; player_v=40, fire_rise -> refused, shots unchanged.
REQ-038 reset asserted mid-FLY with fire=1 -> IDLE, PARK, shots=0; release with fire held -> no launch.
